prt_dptx_scrm: RTL and testbench
================================

Name: prt_dptx_scrm

Overview:
DP TX link-layer scrambler. It sits between the TX framer/MTP formatter and the 8b/10b encoder/PHY. In SST it replaces every 512th BS with SR and resets the LFSR after each SR. It scrambles data symbols with the x^16+x^5+x^4+x^3+1 LFSR and, in MST, scrambles K-symbols by index remapping, so the block is the exact inverse of the DP RX scrambler.

Parameters:
P_SIM, 0, simulation mode; no RTL effect except SR interval (see Optional Feature)
P_SPL, 2, symbols per lane per clock (1, 2 or 4)

Ports:
RST_IN  input  1  reset, asynchronous, active-high
CLK_IN  input  1  link clock
CTL_EN_IN  input  1  scrambler enable; registered internally
CTL_MST_IN  input  1  MST mode; registered internally
LNK_K_IN  input  P_SPL  K flag per sublane (sublane 0 = earliest symbol)
LNK_DAT_IN  input  P_SPL*8  symbol bytes, sublane i at [8i+7:8i]
LNK_K_OUT  output  P_SPL  K flag out
LNK_DAT_OUT  output  P_SPL*8  scrambled symbols out
SR_STB_OUT  output  1  one-clock pulse when an SR is emitted in the output word

Behaviour:
- Reset: LNK_K_OUT=0, LNK_DAT_OUT=0, SR_STB_OUT=0, LFSR register=16'hFFFF, BS counter=0, control registers=0.
- Latency: fixed 1 clock from input word to output word. There is no handshake; one word is accepted every clock.
- LFSR step: 8 serial shifts per symbol, expressed as a 16-bit parallel function calc_lfsr. Sublane i uses L[i] = calc_lfsr(L[i-1]). L[-1] is the LFSR register, which is updated to L[P_SPL-1] every clock.
- LFSR reset: if sublane i-1 holds an SR, L[i] = 16'hFFFF. For i=0 this refers to sublane P_SPL-1 of the previous clock, held in a registered flag.
- Data symbol (K=0), enabled: out[j] = in[j] ^ L[i][15-j], for j = 0..7.
- SST (CTL_MST=0), enabled:
  - BS = K28.5, SR = K28.0.
  - A 9-bit BS counter is evaluated per BS in sublane order within a word.
  - If the counter is 0, that BS is emitted as SR and counts as the SR symbol for the LFSR reset.
  - The counter increments on each BS and wraps 511->0.
  - Any other K-symbol passes unchanged.
  - Two BS in one word are each counted; at most one can hit 0.
- MST (CTL_MST=1), enabled:
  - SR = K28.5, supplied upstream; no substitution; the BS counter is held at 0.
  - K28.5 passes unchanged and triggers the LFSR reset.
  - Other K-symbols in the 8-entry table {K23.7, K27.7, K28.0, K28.2, K28.3, K28.6, K29.7, K30.7} map to idx.
  - idx' = idx ^ {L[i][13], L[i][14], L[i][15]}; the output is table[idx'] with K=1.
  - K-codes outside the table pass unchanged.
- Disabled (CTL_EN=0):
  - Full pass-through, no SR substitution, LFSR still stepping.
  - BS counter cleared to 0, so the first BS after enable becomes SR.
- Mode change: a CTL_MST toggle while enabled clears the BS counter. The LFSR continues until the next SR.
- SR_STB_OUT: registered with the output word. It is high if any output sublane carries SR (SST, substituted) or K28.5 (MST).
- Reset mid-operation: all state returns asynchronously to reset values. After release the first emitted BS becomes SR.

Optional Feature:
- PRT_DPTX_SCRM_SHORT_SR_EN defined: the SR interval is 8 BS (counter 3 bits, wrap 7->0), for fast simulation of LFSR resync.
- Undefined: the interval is 512 BS, per the DP specification. All other behaviour is identical.

Decomposition:
- prt_dp_pkg (shared) holds:
  - symbol constants P_SYM_K28_5 (BS), P_SYM_K28_0 (SR) and the eight scramblable K-codes;
  - the calc_lfsr function;
  - the SR interval constant.
- A small sub-module prt_dptx_scrm_kmap (combinational, K-code<->index table plus XOR) is natural and is reusable by the RX side. The LFSR chain stays inline.

Test Plan:
1. SST enabled, P_SPL=2, word {BS, 0x00} then {0x00, 0x00} -> first out {SR(K28.0), 0xFF}, next {0x17, 0xC0}; SR_STB_OUT=1 for one clock.
2. SST, BS sent 1025 times -> SR at BS #1, #513, #1025; all others remain K28.5; SR_STB_OUT pulses exactly 3 times.
3. BS in sublane P_SPL-1 with counter=0 -> next clock's sublane 0 data 0x00 outputs 0xFF, proving the registered cross-word reset.
4. MST enabled, K28.5 then K23.7 in the next sublane -> K28.5 unchanged. K23.7 (idx 0) with L=FFFF gives idx' 7 -> output K30.7.
5. CTL_EN=0 with arbitrary words -> output equals input delayed 1 clock. Re-enable -> first BS becomes SR.
6. Assert RST_IN mid-stream -> outputs 0 immediately. After release the first BS becomes SR and data scrambles from FFFF.

Source files
------------

// File: rtl/prt_dp_pkg.sv
// Shared DisplayPort link-layer constants and the scrambler LFSR step.
// PRT_DPTX_SCRM_SHORT_SR_EN shortens the SR interval from 512 to 8 BS.
package prt_dp_pkg;

    localparam logic [7:0] P_SYM_K28_5 = 8'hBC;  // BS (SST) / SR (MST)
    localparam logic [7:0] P_SYM_K28_0 = 8'h1C;  // SR (SST)
    localparam logic [7:0] P_SYM_K23_7 = 8'hF7;
    localparam logic [7:0] P_SYM_K27_7 = 8'hFB;
    localparam logic [7:0] P_SYM_K28_2 = 8'h5C;
    localparam logic [7:0] P_SYM_K28_3 = 8'h7C;
    localparam logic [7:0] P_SYM_K28_6 = 8'hDC;
    localparam logic [7:0] P_SYM_K29_7 = 8'hFD;
    localparam logic [7:0] P_SYM_K30_7 = 8'hFE;

    localparam logic [7:0] P_KSYM_TBL [8] = '{
        P_SYM_K23_7, P_SYM_K27_7, P_SYM_K28_0, P_SYM_K28_2,
        P_SYM_K28_3, P_SYM_K28_6, P_SYM_K29_7, P_SYM_K30_7
    };

    localparam logic [15:0] P_LFSR_SEED = 16'hFFFF;

    // SR interval is 2**width BS; the counter wraps naturally.
    localparam int unsigned P_SR_CNT_W_SIM = 3;
`ifdef PRT_DPTX_SCRM_SHORT_SR_EN
    localparam int unsigned P_SR_CNT_W = P_SR_CNT_W_SIM;
`else
    localparam int unsigned P_SR_CNT_W = 9;
`endif

    // Eight serial shifts of the Galois x^16+x^5+x^4+x^3+1 register.
    function automatic logic [15:0] calc_lfsr(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int unsigned n = 0; n < 8; n++) begin
            r = {r[14:5], r[4] ^ r[15], r[3] ^ r[15], r[2] ^ r[15], r[1:0], r[15]};
        end
        return r;
    endfunction

    // Data key: symbol bit j is XORed with LFSR bit 15-j.
    function automatic logic [7:0] calc_scr_mask(input logic [15:0] l);
        logic [7:0] m;
        for (int unsigned j = 0; j < 8; j++) begin
            m[j] = l[15 - j];
        end
        return m;
    endfunction

endpackage

// File: rtl/prt_dptx_scrm_kmap.sv
// K-code remap: table lookup, index XOR key, table readback. Pure combinational.
module prt_dptx_scrm_kmap
    import prt_dp_pkg::*;
(
    input  logic [7:0] SYM_IN,
    input  logic [2:0] KEY_IN,
    output logic [7:0] SYM_OUT,
    output logic       HIT_OUT
);

    logic [2:0] idx;
    logic       hit;

    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int unsigned n = 0; n < 8; n++) begin
            if (SYM_IN == P_KSYM_TBL[n]) begin
                hit = 1'b1;
                idx = 3'(n);
            end
        end
        SYM_OUT = hit ? P_KSYM_TBL[idx ^ KEY_IN] : SYM_IN;
        HIT_OUT = hit;
    end

endmodule

// File: rtl/prt_dptx_scrm.sv
// DP TX link-layer scrambler: SR insertion (SST), data LFSR scrambling, K remap (MST).
// PRT_DPTX_SCRM_SHORT_SR_EN (or P_SIM != 0) selects the 8-BS SR interval.
module prt_dptx_scrm
    import prt_dp_pkg::*;
#(
    parameter int P_SIM = 0,
    parameter int P_SPL = 2
)
(
    input  logic                 RST_IN,
    input  logic                 CLK_IN,
    input  logic                 CTL_EN_IN,
    input  logic                 CTL_MST_IN,
    input  logic [P_SPL-1:0]     LNK_K_IN,
    input  logic [P_SPL*8-1:0]   LNK_DAT_IN,
    output logic [P_SPL-1:0]     LNK_K_OUT,
    output logic [P_SPL*8-1:0]   LNK_DAT_OUT,
    output logic                 SR_STB_OUT
);

    localparam int unsigned CNT_W = (P_SIM != 0) ? P_SR_CNT_W_SIM : P_SR_CNT_W;

    logic                     en_r;
    logic                     mst_r;
    logic                     sr_r;
    logic [15:0]              lfsr_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [P_SPL-1:0]         k_r;
    logic [P_SPL*8-1:0]       dat_r;
    logic                     stb_r;

    logic [P_SPL-1:0][15:0]   l_chain;
    logic [P_SPL-1:0]         sr_vec;
    logic [CNT_W-1:0]         cnt_v;
    logic [CNT_W-1:0]         cnt_nxt;
    logic [15:0]              l_v;
    logic                     prev_sr;
    logic [P_SPL-1:0]         kmap_hit;
    logic [P_SPL*8-1:0]       kmap_sym;
    logic [P_SPL-1:0]         k_nxt;
    logic [P_SPL*8-1:0]       dat_nxt;

    // SR detection and LFSR chain; SR in sublane i-1 reseeds sublane i.
    always_comb begin
        l_chain = '0;
        sr_vec  = '0;
        cnt_v   = cnt_r;
        l_v     = lfsr_r;
        prev_sr = sr_r;
        for (int unsigned i = 0; i < P_SPL; i++) begin
            l_v        = prev_sr ? P_LFSR_SEED : calc_lfsr(l_v);
            l_chain[i] = l_v;
            if (en_r && LNK_K_IN[i] && LNK_DAT_IN[8*i +: 8] == P_SYM_K28_5) begin
                if (mst_r) begin
                    sr_vec[i] = 1'b1;
                end else begin
                    sr_vec[i] = (cnt_v == '0);
                    cnt_v     = cnt_v + CNT_W'(1);
                end
            end
            prev_sr = sr_vec[i];
        end
        cnt_nxt = (!en_r || mst_r || (CTL_MST_IN != mst_r)) ? '0 : cnt_v;
    end

    for (genvar g = 0; g < P_SPL; g++) begin : g_kmap
        prt_dptx_scrm_kmap u_kmap (
            .SYM_IN  (LNK_DAT_IN[8*g +: 8]),
            .KEY_IN  ({l_chain[g][13], l_chain[g][14], l_chain[g][15]}),
            .SYM_OUT (kmap_sym[8*g +: 8]),
            .HIT_OUT (kmap_hit[g])
        );
    end

    always_comb begin
        k_nxt   = LNK_K_IN;
        dat_nxt = LNK_DAT_IN;
        for (int unsigned i = 0; i < P_SPL; i++) begin
            if (en_r) begin
                if (!LNK_K_IN[i]) begin
                    dat_nxt[8*i +: 8] = LNK_DAT_IN[8*i +: 8] ^ calc_scr_mask(l_chain[i]);
                end else if (!mst_r && sr_vec[i]) begin
                    dat_nxt[8*i +: 8] = P_SYM_K28_0;
                end else if (mst_r && kmap_hit[i]) begin
                    dat_nxt[8*i +: 8] = kmap_sym[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            en_r   <= 1'b0;
            mst_r  <= 1'b0;
            sr_r   <= 1'b0;
            lfsr_r <= P_LFSR_SEED;
            cnt_r  <= '0;
            k_r    <= '0;
            dat_r  <= '0;
            stb_r  <= 1'b0;
        end else begin
            en_r   <= CTL_EN_IN;
            mst_r  <= CTL_MST_IN;
            sr_r   <= sr_vec[P_SPL-1];
            lfsr_r <= l_chain[P_SPL-1];
            cnt_r  <= cnt_nxt;
            k_r    <= k_nxt;
            dat_r  <= dat_nxt;
            stb_r  <= |sr_vec;
        end
    end

    assign LNK_K_OUT   = k_r;
    assign LNK_DAT_OUT = dat_r;
    assign SR_STB_OUT  = stb_r;

endmodule

// File: tb/tb_prt_dptx_scrm.sv
// Bench for prt_dptx_scrm (P_SPL=2): constant vector table, then a reference model.
module tb_prt_dptx_scrm;

    localparam int SPL = 2;
`ifdef PRT_DPTX_SCRM_SHORT_SR_EN
    localparam int IV = 8;
`else
    localparam int IV = 512;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        mst = 1'b0;
    logic [1:0]  k_in = '0;
    logic [15:0] dat_in = '0;
    logic [1:0]  k_out;
    logic [15:0] dat_out;
    logic        stb;

    always #5 clk = ~clk;

    prt_dptx_scrm #(.P_SIM(0), .P_SPL(SPL)) dut (
        .RST_IN      (rst),
        .CLK_IN      (clk),
        .CTL_EN_IN   (en),
        .CTL_MST_IN  (mst),
        .LNK_K_IN    (k_in),
        .LNK_DAT_IN  (dat_in),
        .LNK_K_OUT   (k_out),
        .LNK_DAT_OUT (dat_out),
        .SR_STB_OUT  (stb)
    );

    typedef struct {
        int          id;
        logic [1:0]  k;
        logic [15:0] dat;
        logic        sr;
    } exp_t;

    typedef struct {
        logic        en;
        logic        mst;
        logic [1:0]  k;
        logic [15:0] dat;
        logic [1:0]  ek;
        logic [15:0] edat;
        logic        esr;
    } vec_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_word = 0;
    int   stb_cnt = 0;

    // reference model state
    logic [15:0] m_lfsr;
    bit          m_srp;
    int          m_cnt;
    bit          m_en;
    bit          m_mst;
    logic [7:0]  ktbl [8] = '{8'hF7, 8'hFB, 8'h1C, 8'h5C, 8'h7C, 8'hDC, 8'hFD, 8'hFE};

    function automatic logic [15:0] adv(input logic [15:0] s);
        logic [15:0] r;
        logic        fb;
        r = s;
        for (int b = 0; b < 8; b++) begin
            fb = r[15];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h0039;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hFFFF;
        m_srp  = 0;
        m_cnt  = 0;
        m_en   = 0;
        m_mst  = 0;
    endtask

    task automatic model_word(input logic en_in, input logic mst_in, input logic [1:0] k,
                              input logic [15:0] d, output exp_t e);
        logic [15:0] l;
        logic [7:0]  s;
        logic [7:0]  o;
        bit          srp;
        int          cnt;
        int          hit;
        l = m_lfsr; srp = m_srp; cnt = m_cnt;
        e.id = n_word; e.k = k; e.dat = d; e.sr = 1'b0;
        for (int i = 0; i < SPL; i++) begin
            s = d[8*i +: 8];
            o = s;
            l = srp ? 16'hFFFF : adv(l);
            srp = 0;
            if (m_en) begin
                if (!k[i]) begin
                    for (int j = 0; j < 8; j++) o[j] = s[j] ^ l[15-j];
                end else if (s == 8'hBC) begin
                    if (m_mst) begin
                        srp = 1; e.sr = 1'b1;
                    end else begin
                        if (cnt == 0) begin o = 8'h1C; srp = 1; e.sr = 1'b1; end
                        cnt = (cnt + 1) % IV;
                    end
                end else if (m_mst) begin
                    hit = -1;
                    for (int n = 0; n < 8; n++) if (ktbl[n] == s) hit = n;
                    if (hit >= 0) o = ktbl[hit ^ int'({l[13], l[14], l[15]})];
                end
            end
            e.dat[8*i +: 8] = o;
        end
        m_lfsr = l;
        m_srp  = srp;
        m_cnt  = (!m_en || m_mst || (mst_in != m_mst)) ? 0 : cnt;
        m_en   = en_in;
        m_mst  = mst_in;
    endtask

    // Called at a negedge: drive a word, then sample its result at the following negedge.
    task automatic apply(input logic a_en, input logic a_mst, input logic [1:0] a_k,
                         input logic [15:0] a_d, input exp_t e);
        exp_t g;
        en = a_en; mst = a_mst; k_in = a_k; dat_in = a_d;
        sbq.push_back(e);
        n_word++;
        @(negedge clk);
        if (stb) stb_cnt++;
        if (sbq.size() != 0) begin
            g = sbq.pop_front();
            n_vec++;
            if (k_out !== g.k || dat_out !== g.dat || stb !== g.sr) begin
                n_err++;
                $display("FAIL word%0d: got k=%b dat=%h stb=%b, want k=%b dat=%h stb=%b",
                         g.id, k_out, dat_out, stb, g.k, g.dat, g.sr);
            end
        end
    endtask

    task automatic apply_m(input logic a_en, input logic a_mst, input logic [1:0] a_k,
                           input logic [15:0] a_d);
        exp_t e;
        model_word(a_en, a_mst, a_k, a_d, e);
        apply(a_en, a_mst, a_k, a_d, e);
    endtask

    task automatic check_zero(input string nm);
        n_vec++;
        if (k_out !== '0 || dat_out !== '0 || stb !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got k=%b dat=%h stb=%b, want all zero", nm, k_out, dat_out, stb);
        end
    endtask

    // Called at a negedge; asserts reset between edges, returns at a later negedge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        en = 1'b0; mst = 1'b0; k_in = '0; dat_in = '0;
        sbq.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] pick_k();
        logic [7:0] lst [12] = '{8'hBC, 8'hBC, 8'hBC, 8'h1C, 8'hF7, 8'hFB,
                                 8'h5C, 8'h7C, 8'hDC, 8'hFD, 8'hFE, 8'h3C};
        return lst[$urandom_range(0, 11)];
    endfunction

    vec_t tbl [11];

    initial begin
        logic [1:0]  rk;
        logic [15:0] rd;
        logic        ren;
        logic        rmst;
        exp_t        e;

        //            en    mst   k      dat        ek     edat       esr
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 16'h0000, 2'b00, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'b01, 16'h00BC, 2'b01, 16'hFF1C, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 2'b00, 16'h0000, 2'b00, 16'hC017, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 2'b00, 16'h0000, 2'b00, 16'hB214, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 2'b00, 16'h1234, 2'b00, 16'h1234, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'b10, 16'hBC00, 2'b10, 16'h1C82, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 2'b00, 16'h0000, 2'b00, 16'h17FF, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 2'b00, 16'h0000, 2'b00, 16'h0000, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 2'b11, 16'hF7BC, 2'b11, 16'hFEBC, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 2'b11, 16'h1C1C, 2'b11, 16'h1CDC, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 2'b01, 16'h003C, 2'b01, 16'hB23C, 1'b0};

        #1 check_zero("power_on_reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            if (i == 7) do_reset();
            e.id = n_word; e.k = tbl[i].ek; e.dat = tbl[i].edat; e.sr = tbl[i].esr;
            apply(tbl[i].en, tbl[i].mst, tbl[i].k, tbl[i].dat, e);
        end

        // SR cadence over 1025 BS
        do_reset();
        apply_m(1'b1, 1'b0, 2'b00, 16'h0000);
        stb_cnt = 0;
        for (int b = 0; b < 1025; b++) begin
            apply_m(1'b1, 1'b0, 2'b01, {8'($urandom_range(0, 255)), 8'hBC});
        end
        n_vec++;
        if (stb_cnt != (1024 / IV) + 1) begin
            n_err++;
            $display("FAIL sr_count: got %0d strobes, want %0d", stb_cnt, (1024 / IV) + 1);
        end

        // random traffic with enable/mode toggles and a mid-stream reset
        ren = 1'b1; rmst = 1'b0;
        for (int w = 0; w < 400; w++) begin
            if ($urandom_range(0, 24) == 0) ren = ~ren;
            if ($urandom_range(0, 29) == 0) rmst = ~rmst;
            rk = 2'($urandom_range(0, 3));
            for (int i = 0; i < SPL; i++) begin
                rd[8*i +: 8] = rk[i] ? pick_k() : 8'($urandom_range(0, 255));
            end
            if (w == 200) begin
                do_reset();
                apply_m(1'b1, 1'b0, 2'b00, 16'h0000);
                apply_m(1'b1, 1'b0, 2'b01, 16'h00BC);
                apply_m(1'b1, 1'b0, 2'b00, 16'h0000);
                ren = 1'b1; rmst = 1'b0;
            end
            apply_m(ren, rmst, rk, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
